apb_cmd_master: RTL and testbench

//  Synthesizable APB (APB2: no PREADY/PSLVERR) master that sits upstream of the APB GPIO

---
 rtl/apb_cmd_master.sv | 155 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB2 master fed by a buffered valid/ready command stream
//
// Purpose: accepts (addr, write, wdata) commands into a small FIFO, issues each as one
// APB SETUP+ACCESS transfer in arrival order and returns one response per command.
//
// Ports:
//   PCLK, PRESETn                  clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_ready = FIFO not full
//   cmd_addr/cmd_write/cmd_wdata   command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready            response handshake
//   rsp_write/rsp_data             direction echo; PRDATA for reads, 0 for writes
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PRDATA  APB2 bus (no PREADY/PSLVERR)
//   busy                           FSM not IDLE or FIFO non-empty

module apb_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_data,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE_C = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE_C = (FIFO_AW)'(1);

  // Command storage; contents need no reset since count_q gates every read.
  logic [31:0]        mem_addr_q  [FIFO_DEPTH];
  logic               mem_write_q [FIFO_DEPTH];
  logic [31:0]        mem_wdata_q [FIFO_DEPTH];

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;

  state_t             state_q;
  logic               psel_q, penable_q, pwrite_q;
  logic [31:0]        paddr_q, pwdata_q;
  logic               rsp_valid_q, rsp_write_q;
  logic [31:0]        rsp_data_q;

  logic               push, pop;

  // Full is judged on registered count only, so a same-cycle pop never
  // lets a push through into a full FIFO.
  assign cmd_ready = (count_q != DEPTH_C);
  assign busy      = (state_q != ST_IDLE) || (count_q != '0);

  always_comb begin
    push     = cmd_valid && (count_q != DEPTH_C);
    pop      = (state_q == ST_IDLE) && (count_q != '0);
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]  <= cmd_addr;
      mem_write_q[wr_ptr_q] <= cmd_write;
      mem_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            paddr_q   <= mem_addr_q[rd_ptr_q];
            pwrite_q  <= mem_write_q[rd_ptr_q];
            pwdata_q  <= mem_write_q[rd_ptr_q] ? mem_wdata_q[rd_ptr_q] : 32'h0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // No wait states: PRDATA is valid at the closing edge of ACCESS.
          rsp_data_q  <= pwrite_q ? 32'h0 : PRDATA;
          rsp_write_q <= pwrite_q;
          rsp_valid_q <= 1'b1;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master

module tb_apb_cmd_master;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        busy;

  int          n_checks;
  int          n_fail;

  // Slave model: 0 = fixed read data, 1 = returns ~PADDR, 2 = GPIO register block
  int          slave_mode;
  logic [31:0] fixed_rdata;
  logic [31:0] gpio_ctrl;
  logic [31:0] gpio_line;
  logic [31:0] gpio_pins;

  apb_cmd_master #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .busy      (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // GPIO map: CONTROL @0x0 (1 = output-enabled bit), LINE @0x4, IRQ @0x8.
  // Reading LINE returns driven bits where enabled, input pins elsewhere.
  always_comb begin
    PRDATA = 32'h0;
    case (slave_mode)
      0: PRDATA = fixed_rdata;
      1: PRDATA = ~PADDR;
      2: begin
        case (PADDR)
          32'h0:   PRDATA = gpio_ctrl;
          32'h4:   PRDATA = (gpio_line & gpio_ctrl) | (gpio_pins & ~gpio_ctrl);
          default: PRDATA = 32'h0;
        endcase
      end
      default: PRDATA = 32'h0;
    endcase
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gpio_ctrl <= 32'h0;
      gpio_line <= 32'h0;
    end else if (slave_mode == 2 && PSEL && PENABLE && PWRITE) begin
      if (PADDR == 32'h0) gpio_ctrl <= PWDATA;
      if (PADDR == 32'h4) gpio_line <= PWDATA;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_checks++;
    if (obs !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int c;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 20) begin
      tick();
      c++;
    end
    check_eq("txn_rsp_seen", {31'h0, rsp_valid}, 32'h1);
    rd = rsp_data;
    tick();
  endtask

  logic [31:0] rd;
  logic [12:0] psel_v, pen_v, rv_v, busy_v;
  logic [31:0] wd_seen [3];
  int          nwd;
  int          got;
  logic        seen;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    slave_mode  = 0;
    fixed_rdata = 32'hCAFE_BABE;
    gpio_pins   = 32'hFFFF_FFFF;
    PRESETn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = 32'h0;
    cmd_write   = 1'b0;
    cmd_wdata   = 32'h0;
    rsp_ready   = 1'b1;

    tick();
    tick();
    check_eq("rst_psel",      {31'h0, PSEL},      32'h0);
    check_eq("rst_penable",   {31'h0, PENABLE},   32'h0);
    check_eq("rst_paddr",     PADDR,              32'h0);
    check_eq("rst_pwdata",    PWDATA,             32'h0);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("rst_busy",      {31'h0, busy},      32'h0);
    PRESETn = 1'b1;
    tick();

    // 1: single write
    cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b1; cmd_wdata = 32'hFFFF_0000;
    tick();
    cmd_valid = 1'b0;
    check_eq("t1_busy_after_push", {31'h0, busy}, 32'h1);
    check_eq("t1_psel_n0",         {31'h0, PSEL}, 32'h0);
    tick();
    check_eq("t1_setup_psel",    {31'h0, PSEL},    32'h1);
    check_eq("t1_setup_penable", {31'h0, PENABLE}, 32'h0);
    check_eq("t1_setup_paddr",   PADDR,            32'h20);
    check_eq("t1_setup_pwrite",  {31'h0, PWRITE},  32'h1);
    check_eq("t1_setup_pwdata",  PWDATA,           32'hFFFF_0000);
    tick();
    check_eq("t1_access_penable", {31'h0, PENABLE}, 32'h1);
    check_eq("t1_access_pwdata",  PWDATA,           32'hFFFF_0000);
    tick();
    check_eq("t1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("t1_rsp_write", {31'h0, rsp_write}, 32'h1);
    check_eq("t1_rsp_data",  rsp_data,           32'h0);
    check_eq("t1_psel_drop", {31'h0, PSEL},      32'h0);
    tick();
    check_eq("t1_rsp_cleared", {31'h0, rsp_valid}, 32'h0);
    check_eq("t1_busy_idle",   {31'h0, busy},      32'h0);

    // 2: single read, response exactly three edges after the push edge
    fixed_rdata = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_addr = 32'h24; cmd_write = 1'b0; cmd_wdata = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("t2_pwrite", {31'h0, PWRITE}, 32'h0);
    check_eq("t2_pwdata", PWDATA,          32'h0);
    check_eq("t2_paddr",  PADDR,           32'h24);
    tick();
    check_eq("t2_rsp_not_yet", {31'h0, rsp_valid}, 32'h0);
    tick();
    check_eq("t2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("t2_rsp_data",  rsp_data,           32'h1234_5678);
    check_eq("t2_rsp_write", {31'h0, rsp_write}, 32'h0);
    tick();

    // 3: response stall, fill FIFO, then drain in order
    slave_mode = 1;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h100 + 32'(4 * i); cmd_write = 1'b0; cmd_wdata = 32'h0;
      tick();
    end
    check_eq("t3_full_ready", {31'h0, cmd_ready}, 32'h0);
    check_eq("t3_stall_rv",   {31'h0, rsp_valid}, 32'h1);
    check_eq("t3_stall_data", rsp_data,           ~32'h100);
    check_eq("t3_bus_idle",   {31'h0, PSEL},      32'h0);
    cmd_addr = 32'h200;
    tick();
    tick();
    cmd_valid = 1'b0;
    check_eq("t3_still_full", {31'h0, cmd_ready}, 32'h0);
    check_eq("t3_data_hold",  rsp_data,           ~32'h100);
    check_eq("t3_write_hold", {31'h0, rsp_write}, 32'h0);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (rsp_valid) begin
        check_eq($sformatf("t3_order%0d", got), rsp_data, ~(32'h100 + 32'(4 * got)));
        got++;
      end
      tick();
    end
    check_eq("t3_drained", 32'(got), 32'd5);
    tick();
    check_eq("t3_no_extra_rsp", {31'h0, rsp_valid}, 32'h0);
    check_eq("t3_busy_done",    {31'h0, busy},      32'h0);

    // 4: three back-to-back writes, rsp_ready held high
    slave_mode = 0;
    nwd = 0;
    for (int i = 0; i < 13; i++) begin
      cmd_valid = (i < 3);
      cmd_addr  = 32'h40 + 32'(4 * i);
      cmd_write = 1'b1;
      cmd_wdata = 32'hA000_0000 + 32'(i);
      tick();
      psel_v[i] = PSEL;
      pen_v[i]  = PENABLE;
      rv_v[i]   = rsp_valid;
      busy_v[i] = busy;
      if (PSEL && PENABLE && nwd < 3) begin
        wd_seen[nwd] = PWDATA;
        nwd++;
      end
    end
    cmd_valid = 1'b0;
    check_eq("t4_psel_pattern", {19'h0, psel_v}, 32'h0666);
    check_eq("t4_pen_pattern",  {19'h0, pen_v},  32'h0444);
    check_eq("t4_rsp_pattern",  {19'h0, rv_v},   32'h0888);
    check_eq("t4_busy_pattern", {19'h0, busy_v}, 32'h0FFF);
    check_eq("t4_wd_count", 32'(nwd), 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("t4_wd%0d", i), wd_seen[i], 32'hA000_0000 + 32'(i));

    // 5: reset during ACCESS with a second command still queued
    tick();
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_write = 1'b1; cmd_wdata = 32'h55;
    tick();
    cmd_addr = 32'h84;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("t5_in_access", {31'h0, PENABLE}, 32'h1);
    #2;
    PRESETn = 1'b0;
    #1;
    check_eq("t5_psel",      {31'h0, PSEL},      32'h0);
    check_eq("t5_penable",   {31'h0, PENABLE},   32'h0);
    check_eq("t5_pwrite",    {31'h0, PWRITE},    32'h0);
    check_eq("t5_paddr",     PADDR,              32'h0);
    check_eq("t5_pwdata",    PWDATA,             32'h0);
    check_eq("t5_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("t5_rsp_data",  rsp_data,           32'h0);
    check_eq("t5_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("t5_busy",      {31'h0, busy},      32'h0);
    tick();
    tick();
    PRESETn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | rsp_valid | PSEL;
    end
    check_eq("t5_no_activity", {31'h0, seen}, 32'h0);
    fixed_rdata = 32'h0BAD_F00D;
    do_txn(32'h48, 1'b0, 32'h0, rd);
    check_eq("t5_fresh_read", rd, 32'h0BAD_F00D);

    // 6: GPIO register block
    slave_mode = 2;
    do_txn(32'h0, 1'b1, 32'h0,         rd);
    check_eq("t6_wr_rsp", rd, 32'h0);
    do_txn(32'h4, 1'b1, 32'hAAAA_5555, rd);
    do_txn(32'h0, 1'b1, 32'hFFFF_0000, rd);
    do_txn(32'h4, 1'b0, 32'h0,         rd);
    check_eq("t6_line", rd, 32'hAAAA_FFFF);
    do_txn(32'h8, 1'b0, 32'h0,         rd);
    check_eq("t6_irq",  rd, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
